// File: rtl/mem_wb_r.sv
// Memory-access / writeback pipeline stage: drives the data-memory req/ack bus for
// loads and stores, and produces the register-file write triple plus stall/flush.
module mem_wb_r (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        valid_i,
  input  logic        flush_i,
  input  logic [31:0] inst_i,
  input  logic [31:0] alu_result_i,
  input  logic [31:0] store_data_i,
  input  logic [3:0]  rd_addr_i,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_ack_i,
  input  logic [31:0] dmem_rdata_i,
  output logic        wb_en_o,
  output logic [3:0]  wb_addr_o,
  output logic [31:0] wb_data_o,
  output logic        stall_o,
  output logic        flush_o
);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e      state_q, state_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  rd_q, rd_d;
  logic        wb_en_q, wb_en_d;
  logic [3:0]  wb_addr_q, wb_addr_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic        flush_q, flush_d;
  logic        pend_valid_q, pend_valid_d;
  logic [3:0]  pend_addr_q, pend_addr_d;
  logic [31:0] pend_data_q, pend_data_d;

  logic busy, stall, accept, is_mem, alu_wr, complete;

  always_comb begin
    busy     = (state_q == BUSY);
    stall    = busy && !dmem_ack_i;
    complete = busy && dmem_ack_i;
    accept   = valid_i && !flush_i && !stall;
    is_mem   = (inst_i[27:26] == 2'b01);
    // TST/TEQ/CMP/CMN are opcodes 1000-1011, i.e. opcode[3:2] == 2'b10.
    alu_wr   = (inst_i[27:26] == 2'b00) && (inst_i[24:23] != 2'b10);
  end

  // NOTE: every signal written here gets a default first, so no path leaves a
  // variable unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rd_d         = rd_q;
    wb_en_d      = 1'b0;
    wb_addr_d    = 4'd0;
    wb_data_d    = 32'd0;
    pend_valid_d = 1'b0;
    pend_addr_d  = pend_addr_q;
    pend_data_d  = pend_data_q;

    if (complete) begin
      state_d = IDLE;
      if (!we_q) begin
        wb_en_d   = 1'b1;
        wb_addr_d = rd_q;
        wb_data_d = dmem_rdata_i;
      end
    end

    // A held-over ALU result only exists in IDLE, so it never meets a load completion.
    if (pend_valid_q) begin
      wb_en_d   = 1'b1;
      wb_addr_d = pend_addr_q;
      wb_data_d = pend_data_q;
    end

    if (accept) begin
      if (is_mem) begin
        state_d = BUSY;
        we_d    = !inst_i[20];
        addr_d  = alu_result_i;
        wdata_d = store_data_i;
        rd_d    = rd_addr_i;
      end else if (alu_wr) begin
        // Write port already taken this edge: keep program order by deferring one cycle.
        if (wb_en_d) begin
          pend_valid_d = 1'b1;
          pend_addr_d  = rd_addr_i;
          pend_data_d  = alu_result_i;
        end else begin
          wb_en_d   = 1'b1;
          wb_addr_d = rd_addr_i;
          wb_data_d = alu_result_i;
        end
      end
    end

    flush_d = wb_en_d && (wb_addr_d == 4'd15);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of the others.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q      <= IDLE;
      we_q         <= 1'b0;
      addr_q       <= 32'd0;
      wdata_q      <= 32'd0;
      rd_q         <= 4'd0;
      wb_en_q      <= 1'b0;
      wb_addr_q    <= 4'd0;
      wb_data_q    <= 32'd0;
      flush_q      <= 1'b0;
      pend_valid_q <= 1'b0;
      pend_addr_q  <= 4'd0;
      pend_data_q  <= 32'd0;
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rd_q         <= rd_d;
      wb_en_q      <= wb_en_d;
      wb_addr_q    <= wb_addr_d;
      wb_data_q    <= wb_data_d;
      flush_q      <= flush_d;
      pend_valid_q <= pend_valid_d;
      pend_addr_q  <= pend_addr_d;
      pend_data_q  <= pend_data_d;
    end
  end

  // Bus outputs follow the state flop directly so reset drops the request at once.
  always_comb begin
    dmem_req_o   = busy;
    dmem_we_o    = busy ? we_q : 1'b0;
    dmem_addr_o  = busy ? addr_q : 32'd0;
    dmem_wdata_o = busy ? wdata_q : 32'd0;
    stall_o      = stall;
    wb_en_o      = wb_en_q;
    wb_addr_o    = wb_addr_q;
    wb_data_o    = wb_data_q;
    flush_o      = flush_q;
  end

endmodule

// File: tb/tb_mem_wb_r.sv
// Randomized bench for mem_wb_r: a queue-based reference model predicts bus activity,
// stall and the in-order writeback stream cycle by cycle.
module tb_mem_wb_r;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b0;
  logic        valid_i = 1'b0, flush_i = 1'b0;
  logic [31:0] inst_i = '0, alu_result_i = '0, store_data_i = '0;
  logic [3:0]  rd_addr_i = '0;
  logic        dmem_ack_i = 1'b0;
  logic [31:0] dmem_rdata_i = '0;
  logic        dmem_req_o, dmem_we_o, wb_en_o, stall_o, flush_o;
  logic [31:0] dmem_addr_o, dmem_wdata_o, wb_data_o;
  logic [3:0]  wb_addr_o;

  mem_wb_r dut (
    .clk_i(clk_i), .reset_i(reset_i), .valid_i(valid_i), .flush_i(flush_i),
    .inst_i(inst_i), .alu_result_i(alu_result_i), .store_data_i(store_data_i),
    .rd_addr_i(rd_addr_i), .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o),
    .dmem_addr_o(dmem_addr_o), .dmem_wdata_o(dmem_wdata_o), .dmem_ack_i(dmem_ack_i),
    .dmem_rdata_i(dmem_rdata_i), .wb_en_o(wb_en_o), .wb_addr_o(wb_addr_o),
    .wb_data_o(wb_data_o), .stall_o(stall_o), .flush_o(flush_o)
  );

  always #5 clk_i = ~clk_i;

  localparam logic [31:0] ADD = 32'hE080_0000;
  localparam logic [31:0] MOV = 32'hE1A0_0000;
  localparam logic [31:0] CMP = 32'hE150_0000;
  localparam logic [31:0] LDR = 32'hE590_0000;
  localparam logic [31:0] STR = 32'hE580_0000;
  localparam logic [31:0] BR  = 32'hEA00_0000;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: one outstanding memory op plus an ordered queue of pending
  // register writes, drained one per cycle.
  typedef struct { logic [3:0] a; logic [31:0] d; } wb_t;
  wb_t         wbq[$];
  bit          m_busy = 0, m_we = 0;
  logic [31:0] m_addr = '0, m_wdata = '0;
  logic [3:0]  m_rd = '0;
  bit          e_wb = 0;
  logic [3:0]  e_addr = '0;
  logic [31:0] e_data = '0;

  task automatic model_reset();
    wbq.delete();
    m_busy = 0; e_wb = 0; e_addr = '0; e_data = '0;
  endtask

  task automatic model_edge();
    bit acc, writes;
    acc = valid_i && !flush_i && !(m_busy && !dmem_ack_i);
    if (m_busy && dmem_ack_i) begin
      if (!m_we) wbq.push_back('{m_rd, dmem_rdata_i});
      m_busy = 0;
    end
    if (acc) begin
      case (inst_i[27:26])
        2'b01: begin
          m_busy = 1; m_we = (inst_i[20] == 1'b0);
          m_addr = alu_result_i; m_wdata = store_data_i; m_rd = rd_addr_i;
        end
        2'b00: begin
          writes = !(inst_i[24:21] inside {[4'd8:4'd11]});
          if (writes) wbq.push_back('{rd_addr_i, alu_result_i});
        end
        default: ;
      endcase
    end
    if (wbq.size() > 0) begin
      e_wb = 1; e_addr = wbq[0].a; e_data = wbq[0].d; void'(wbq.pop_front());
    end else begin
      e_wb = 0;
    end
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic cycle(input logic v, input logic f, input logic [31:0] inst,
                       input logic [31:0] alu, input logic [31:0] sd, input logic [3:0] rd,
                       input logic ack, input logic [31:0] rdata);
    check("wb_en", wb_en_o, e_wb);
    if (e_wb) begin
      check("wb_addr", wb_addr_o, e_addr);
      check("wb_data", wb_data_o, e_data);
    end
    check("flush_o", flush_o, e_wb && e_addr == 4'd15);
    check("dmem_req", dmem_req_o, m_busy);
    check("dmem_we", dmem_we_o, m_busy && m_we);
    check("dmem_addr", dmem_addr_o, m_busy ? m_addr : 32'd0);
    check("dmem_wdata", dmem_wdata_o, m_busy ? m_wdata : 32'd0);
    valid_i = v; flush_i = f; inst_i = inst; alu_result_i = alu;
    store_data_i = sd; rd_addr_i = rd; dmem_ack_i = ack; dmem_rdata_i = rdata;
    #1;
    check("stall", stall_o, m_busy && !ack);
    @(posedge clk_i);
    model_edge();
    @(negedge clk_i);
  endtask

  task automatic idle(input logic ack);
    cycle(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 4'd0, ack, $urandom);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_req"}, dmem_req_o, 1'b0);
    check({tag, "_we"}, dmem_we_o, 1'b0);
    check({tag, "_addr"}, dmem_addr_o, 32'd0);
    check({tag, "_wdata"}, dmem_wdata_o, 32'd0);
    check({tag, "_wb_en"}, wb_en_o, 1'b0);
    check({tag, "_wb_addr"}, wb_addr_o, 4'd0);
    check({tag, "_wb_data"}, wb_data_o, 32'd0);
    check({tag, "_stall"}, stall_o, 1'b0);
    check({tag, "_flush"}, flush_o, 1'b0);
  endtask

  initial begin
    // Reset held with random inputs.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      valid_i = $urandom; flush_i = $urandom; inst_i = $urandom;
      alu_result_i = $urandom; store_data_i = $urandom; rd_addr_i = $urandom;
      dmem_ack_i = $urandom; dmem_rdata_i = $urandom;
      #1 check_all_zero("reset");
    end
    @(negedge clk_i);
    valid_i = 0; flush_i = 0; dmem_ack_i = 0;
    reset_i = 1'b1;
    model_reset();

    // ADD r3 = 0x1234, then nothing.
    cycle(1, 0, ADD, 32'h1234, 32'h0, 4'd3, 0, 0);
    check("add_wb_en", wb_en_o, 1'b1);
    check("add_wb_data", wb_data_o, 32'h1234);
    idle(0); idle(0);

    // Zero-wait load r5 from 0x40.
    cycle(1, 0, LDR, 32'h40, 32'h0, 4'd5, 0, 0);
    cycle(0, 0, 32'h0, 32'h0, 32'h0, 4'd0, 1, 32'hDEAD_BEEF);
    check("ldr_wb_data", wb_data_o, 32'hDEAD_BEEF);
    idle(0); idle(0);

    // Store 0x55 to 0x80, three wait cycles.
    cycle(1, 0, STR, 32'h80, 32'h55, 4'd1, 0, 0);
    for (int i = 0; i < 3; i++) idle(0);
    idle(1); idle(0); idle(0);

    // Load with ADD presented during the stall, ack on the 2nd request cycle.
    cycle(1, 0, LDR, 32'h200, 32'h0, 4'd7, 0, 0);
    cycle(1, 0, ADD, 32'hAAAA, 32'h0, 4'd8, 0, 0);
    cycle(1, 0, ADD, 32'hAAAA, 32'h0, 4'd8, 1, 32'h1357_9BDF);
    check("b2b_load_first", wb_addr_o, 4'd7);
    idle(0);
    check("b2b_add_second", wb_addr_o, 4'd8);
    idle(0); idle(0);

    // MOV pc, then CMP with Rd=15, then a branch.
    cycle(1, 0, MOV, 32'h100, 32'h0, 4'd15, 0, 0);
    check("mov_flush", flush_o, 1'b1);
    cycle(1, 0, CMP, 32'h5, 32'h0, 4'd15, 0, 0);
    cycle(1, 0, BR, 32'h5, 32'h0, 4'd15, 0, 0);
    idle(0); idle(0);

    // Reset during the 2nd wait cycle of a load.
    cycle(1, 0, LDR, 32'h300, 32'h0, 4'd9, 0, 0);
    idle(0);
    valid_i = 0; dmem_ack_i = 0;
    #2 reset_i = 1'b0;
    #1 check("midreset_req", dmem_req_o, 1'b0);
    check("midreset_wb", wb_en_o, 1'b0);
    model_reset();
    @(negedge clk_i);
    reset_i = 1'b1;
    idle(1); idle(0);
    cycle(1, 0, ADD, 32'h77, 32'h0, 4'd2, 0, 0);
    idle(0);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      logic [31:0] inst;
      int r;
      inst = $urandom;
      r = $urandom_range(0, 9);
      inst[27:26] = (r < 4) ? 2'b00 : (r < 8) ? 2'b01 : (r == 8) ? 2'b10 : 2'b11;
      cycle(($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 1), inst, $urandom,
            $urandom, 4'($urandom), ($urandom_range(0, 9) < 4), $urandom);
    end
    for (int i = 0; i < 8; i++) idle(1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
